// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared FSM encoding and sizing helpers for serial_subtractor
//
// Purpose:
//   Holds the 2-bit FSM state encoding used by the bit-serial subtractor and
//   the constant functions that size its bit counter.
//
// Contents:
//   state_t            2-bit state type
//   S_IDLE/S_SHIFT/S_DONE  state encodings
//   clog2(value)       ceiling log2, constant-evaluable
//   cnt_width(width)   counter width able to hold 0..width
package serial_subtractor_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_SHIFT = 2'd1;
  localparam state_t S_DONE  = 2'd2;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

  // The counter must be able to represent every value from 0 to width.
  function automatic int cnt_width(input int width);
    int w;
    w = clog2(width + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// rtl/serial_subtractor_full_subtractor.sv - one-bit combinational full subtractor cell
//
// Purpose:
//   Computes one bit of x - y - bin and the borrow out of that bit.
//
// Ports:
//   x     in   minuend bit
//   y     in   subtrahend bit
//   bin   in   borrow in
//   d     out  difference bit
//   bout  out  borrow out (1 when x < y + bin)
module full_subtractor
  import serial_subtractor_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  // Borrow when y exceeds x outright, or when they tie and a borrow arrives.
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial WIDTH-bit subtractor, LSB first, one cell plus borrow flop
//
// Purpose:
//   Computes diff = a - b - b_in (modulo 2^WIDTH) over WIDTH clocks using a
//   single full_subtractor cell. Operands are captured when start is accepted
//   in IDLE or DONE; the result registers are written only on the final shift
//   so partial results never appear on diff.
//
// Optional feature (macro SERIAL_SUB_OVF_EN):
//   Adds output ovf, the signed overflow of the subtraction, captured on the
//   final shift cycle and held alongside diff.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   start   in   request; operands sampled on the accepting edge
//   a       in   WIDTH  minuend
//   b       in   WIDTH  subtrahend
//   b_in    in   borrow in
//   busy    out  high while shifting
//   done    out  one-cycle pulse when diff/b_out become valid
//   diff    out  WIDTH  result, held until the next result completes
//   b_out   out  final unsigned borrow
//   ovf     out  signed overflow (SERIAL_SUB_OVF_EN only)
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_q;
  state_t           state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             b_out_q;
  logic [CW-1:0]    cnt_q;

  logic             d_bit;
  logic             bout_bit;
  logic             load;
  logic             last_bit;
  logic [WIDTH-1:0] res_next;

  // A new operation is accepted whenever the datapath is not mid-shift.
  assign load     = start && (state_q != S_SHIFT);
  assign last_bit = (state_q == S_SHIFT) && (cnt_q == CW'(WIDTH - 1));
  assign res_next = {d_bit, res_q[WIDTH-1:1]};

  full_subtractor u_cell (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .bin  (borrow_q),
    .d    (d_bit),
    .bout (bout_bit)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (last_bit) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = start ? S_SHIFT : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_SHIFT: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Operand shift registers, borrow flop, bit counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      b_out_q  <= 1'b0;
      cnt_q    <= '0;
    end else if (load) begin
      a_q      <= a;
      b_q      <= b;
      borrow_q <= b_in;
      cnt_q    <= '0;
    end else if (state_q == S_SHIFT) begin
      a_q      <= a_q >> 1;
      b_q      <= b_q >> 1;
      borrow_q <= bout_bit;
      res_q    <= res_next;
      cnt_q    <= cnt_q + CW'(1);
      // Publish only the completed word so diff never shows a partial result.
      if (last_bit) begin
        diff_q  <= res_next;
        b_out_q <= bout_bit;
      end
    end
  end

  assign diff  = diff_q;
  assign b_out = b_out_q;

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q;

  // On the last shift a_q[0]/b_q[0] hold the operand sign bits and d_bit is
  // the result sign bit; overflow when operand signs differ and the result
  // sign disagrees with the minuend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (!load && last_bit) begin
      ovf_q <= (a_q[0] ^ b_q[0]) & (a_q[0] ^ d_bit);
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor (WIDTH=8)
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         b_out;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int total;
  int bad;
  logic [W-1:0] last_diff;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .b_out (b_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer subtraction; bit W is the unsigned borrow.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic bi);
    int r;
    logic [31:0] rv;
    r  = int'(x) - int'(y) - int'(bi);
    rv = r;
    return rv[W:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation and waits (bounded) for done. Reports the cycle index
  // of done relative to the start cycle, busy cycle count, whether diff held
  // hold_val throughout, and whether done was a single-cycle pulse.
  task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic bini,
                        input logic [W-1:0] hold_val,
                        output logic [W-1:0] rd, output logic rb, output int lat,
                        output int busy_n, output logic held, output logic one_shot);
    int n;
    a = ai; b = bi; b_in = bini; start = 1'b1;
    tick();
    start  = 1'b0;
    n      = 1;
    busy_n = 0;
    held   = 1'b1;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) busy_n++;
      if (diff !== hold_val) held = 1'b0;
      a = W'($urandom); b = W'($urandom); b_in = 1'($urandom);
      tick();
      n++;
    end
    lat = n;
    rd  = diff;
    rb  = b_out;
    tick();
    one_shot = (done === 1'b0) && (busy === 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
    tick(); tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
    total++; if (diff !== '0) begin bad++; $display("FAIL reset_diff got=%h exp=00", diff); end
    total++; if (b_out !== 1'b0) begin bad++; $display("FAIL reset_bout got=%0b exp=0", b_out); end
`ifdef SERIAL_SUB_OVF_EN
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b exp=0", ovf); end
`endif
    rst_n = 1'b1;
    tick();
    last_diff = '0;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [4];
    logic [W-1:0] tb [4];
    logic         tbi [4];
    logic [W-1:0] ed [4];
    logic         eb [4];
    logic [W-1:0] rd;
    logic rb, held, one_shot;
    int lat, busy_n;
    ta = '{8'h05, 8'h03, 8'h00, 8'hA7};
    tb = '{8'h03, 8'h05, 8'h00, 8'hA7};
    tbi = '{1'b0, 1'b0, 1'b1, 1'b1};
    ed = '{8'h02, 8'hFE, 8'hFF, 8'hFF};
    eb = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb[i], tbi[i], last_diff, rd, rb, lat, busy_n, held, one_shot);
      total++; if (rd !== ed[i]) begin bad++; $display("FAIL dir%0d_diff got=%h exp=%h", i, rd, ed[i]); end
      total++; if (rb !== eb[i]) begin bad++; $display("FAIL dir%0d_bout got=%0b exp=%0b", i, rb, eb[i]); end
      total++; if (lat != 9) begin bad++; $display("FAIL dir%0d_latency got=%0d exp=9", i, lat); end
      total++; if (busy_n != 8) begin bad++; $display("FAIL dir%0d_busy_cycles got=%0d exp=8", i, busy_n); end
      total++; if (held !== 1'b1) begin bad++; $display("FAIL dir%0d_diff_hold got=0 exp=1", i); end
      total++; if (one_shot !== 1'b1) begin bad++; $display("FAIL dir%0d_done_pulse got=0 exp=1", i); end
      last_diff = ed[i];
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb_op, rd;
    logic rbi, rb, held, one_shot;
    logic [W:0] exp;
    int lat, busy_n;
    for (int i = 0; i < 12; i++) begin
      ra = W'($urandom); rb_op = W'($urandom); rbi = 1'($urandom);
      exp = ref_sub(ra, rb_op, rbi);
      run_op(ra, rb_op, rbi, last_diff, rd, rb, lat, busy_n, held, one_shot);
      total++; if (rd !== exp[W-1:0]) begin bad++; $display("FAIL rnd%0d_diff a=%h b=%h bi=%0b got=%h exp=%h", i, ra, rb_op, rbi, rd, exp[W-1:0]); end
      total++; if (rb !== exp[W]) begin bad++; $display("FAIL rnd%0d_bout got=%0b exp=%0b", i, rb, exp[W]); end
      total++; if (held !== 1'b1 || lat != 9) begin bad++; $display("FAIL rnd%0d_timing held=%0b lat=%0d exp=1/9", i, held, lat); end
      last_diff = exp[W-1:0];
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 6;
    logic [W-1:0] oa [N];
    logic [W-1:0] ob [N];
    logic         obi [N];
    logic [W:0]   exp;
    int issued, got, since, guard;
    logic stable;
    for (int i = 0; i < N; i++) begin
      oa[i] = W'($urandom); ob[i] = W'($urandom); obi[i] = 1'($urandom);
    end
    start = 1'b1; a = oa[0]; b = ob[0]; b_in = obi[0];
    tick();
    issued = 1; got = 0; since = 1; guard = 0; stable = 1'b1;
    while (got < N && guard < 200) begin
      if (done === 1'b1) begin
        exp = ref_sub(oa[got], ob[got], obi[got]);
        total++; if (diff !== exp[W-1:0]) begin bad++; $display("FAIL b2b%0d_diff got=%h exp=%h", got, diff, exp[W-1:0]); end
        total++; if (b_out !== exp[W]) begin bad++; $display("FAIL b2b%0d_bout got=%0b exp=%0b", got, b_out, exp[W]); end
        total++; if (since != 9) begin bad++; $display("FAIL b2b%0d_interval got=%0d exp=9", got, since); end
        last_diff = exp[W-1:0];
        got++;
        since = 0;
        if (issued < N) begin
          a = oa[issued]; b = ob[issued]; b_in = obi[issued];
          issued++;
        end else begin
          start = 1'b0;
        end
      end else begin
        if (diff !== last_diff) stable = 1'b0;
        a = W'($urandom); b = W'($urandom); b_in = 1'($urandom);
      end
      tick();
      since++;
      guard++;
    end
    start = 1'b0;
    total++; if (got != N) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", got, N); end
    total++; if (stable !== 1'b1) begin bad++; $display("FAIL b2b_diff_stable got=0 exp=1"); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_busy got=%0b exp=0", busy); end
    tick();
  endtask

  task automatic test_start_while_busy();
    logic [W:0] exp;
    int n;
    exp = ref_sub(8'h5A, 8'h33, 1'b0);
    a = 8'h5A; b = 8'h33; b_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    tick(); n++;
    tick(); n++;
    a = 8'h01; b = 8'h02; b_in = 1'b1; start = 1'b1;
    tick(); n++;
    start = 1'b0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    total++; if (diff !== exp[W-1:0]) begin bad++; $display("FAIL sbusy_diff got=%h exp=%h", diff, exp[W-1:0]); end
    total++; if (b_out !== exp[W]) begin bad++; $display("FAIL sbusy_bout got=%0b exp=%0b", b_out, exp[W]); end
    total++; if (n != 9) begin bad++; $display("FAIL sbusy_latency got=%0d exp=9", n); end
    tick();
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL sbusy_no_second busy=%0b done=%0b exp=0/0", busy, done); end
    last_diff = exp[W-1:0];
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] rd;
    logic rb, held, one_shot, saw_done;
    logic [W:0] exp;
    int lat, busy_n;
    a = 8'hC3; b = 8'h5E; b_in = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%0b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rmid_done got=%0b exp=0", done); end
    total++; if (diff !== '0) begin bad++; $display("FAIL rmid_diff got=%h exp=00", diff); end
    total++; if (b_out !== 1'b0) begin bad++; $display("FAIL rmid_bout got=%0b exp=0", b_out); end
    tick();
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
      tick();
    end
    total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL rmid_no_done got=1 exp=0"); end
    exp = ref_sub(8'h9C, 8'h2D, 1'b0);
    run_op(8'h9C, 8'h2D, 1'b0, 8'h00, rd, rb, lat, busy_n, held, one_shot);
    total++; if (rd !== exp[W-1:0] || rb !== exp[W]) begin bad++; $display("FAIL rmid_after got=%h/%0b exp=%h/%0b", rd, rb, exp[W-1:0], exp[W]); end
    total++; if (lat != 9 || held !== 1'b1) begin bad++; $display("FAIL rmid_after_timing lat=%0d held=%0b exp=9/1", lat, held); end
    last_diff = exp[W-1:0];
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf();
    logic [W-1:0] va [5];
    logic [W-1:0] vb [5];
    logic         vbi [5];
    logic [W-1:0] rd;
    logic rb, held, one_shot, eov;
    logic [W:0] exp;
    int lat, busy_n, s;
    va = '{8'h80, 8'h7F, 8'h10, 8'h80, 8'h00};
    vb = '{8'h01, 8'hFF, 8'h01, 8'h00, 8'hFF};
    vbi = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      exp = ref_sub(va[i], vb[i], vbi[i]);
      s = int'($signed(va[i])) - int'($signed(vb[i])) - int'(vbi[i]);
      eov = (s < -128) || (s > 127);
      run_op(va[i], vb[i], vbi[i], last_diff, rd, rb, lat, busy_n, held, one_shot);
      total++; if (rd !== exp[W-1:0]) begin bad++; $display("FAIL ovf%0d_diff got=%h exp=%h", i, rd, exp[W-1:0]); end
      total++; if (ovf !== eov) begin bad++; $display("FAIL ovf%0d_flag got=%0b exp=%0b", i, ovf, eov); end
      last_diff = exp[W-1:0];
    end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
